// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: operation codes and FSM states.
// Op codes 0-3 line up with the datapath's original 2-bit ALU.
package alu_mc_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpAnd  = 3'd2,
        OpNotb = 3'd3,
        OpOr   = 3'd4,
        OpXor  = 3'd5,
        OpShl  = 3'd6,
        OpMul  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle over W cycles.
// done_o flags the edge that completes the last step; product_o then carries the final value.
module alu_mc_mul #(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);

    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    logic [2*W-1:0] a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           busy_q, busy_d;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            a_d    = {{W{1'b0}}, a_i};
            b_d    = b_i;
            prod_d = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            prod_d = prod_q + (b_q[0] ? a_q : '0);
            a_d    = a_q << 1;
            b_d    = b_q >> 1;
            if (cnt_q == CntLast) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == CntLast);
    // Next-state product so the consumer can register it on the completing edge.
    assign product_o = prod_d;

endmodule

// File: rtl/alu_mc.sv
// Parametrised multi-cycle ALU with registered result/flags and valid/ready on both sides.
// Single-cycle ops register on the accepting edge; MUL runs through the iterative multiplier.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] val_A,
    input  logic [W-1:0] val_B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] ALU_out,
    output logic         Z,
    output logic         N,
    output logic         V,
    output logic         C
);

    localparam int unsigned ShW = $clog2(W);
    localparam logic [W:0]  One = (W + 1)'(1);

    state_e       state_q, state_d;
    logic [W-1:0] res_q, res_d;
    logic         z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d;

    op_e          op_sel;
    logic         accept;
    logic         is_mul;
    logic [W-1:0] alu_res;
    logic         alu_v, alu_c;
    logic [W:0]   wide;

    logic           mul_start, mul_busy, mul_done;
    logic [2*W-1:0] mul_prod;

    assign op_sel    = op_e'(op);
    assign out_valid = (state_q == StDone);
    // Gated with rst_n so in_ready reads 0 for the whole reset, not just after it.
    assign in_ready  = rst_n && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
    assign accept    = in_valid && in_ready;
    assign is_mul    = MUL_EN && (op_sel == OpMul);

    // Single-cycle datapath; MUL and illegal codes fall to the all-zero default.
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        wide    = '0;
        case (op_sel)
            OpAdd: begin
                wide    = {1'b0, val_A} + {1'b0, val_B};
                alu_res = wide[W-1:0];
                alu_c   = wide[W];
                alu_v   = (val_A[W-1] == val_B[W-1]) && (alu_res[W-1] != val_A[W-1]);
            end
            OpSub: begin
                wide    = {1'b0, val_A} + {1'b0, ~val_B} + One;
                alu_res = wide[W-1:0];
                alu_c   = wide[W];
                alu_v   = (val_A[W-1] != val_B[W-1]) && (alu_res[W-1] != val_A[W-1]);
            end
            OpAnd:  alu_res = val_A & val_B;
            OpOr:   alu_res = val_A | val_B;
            OpXor:  alu_res = val_A ^ val_B;
            OpNotb: alu_res = ~val_B;
            OpShl: begin
                wide    = {1'b0, val_A} << val_B[ShW-1:0];
                alu_res = wide[W-1:0];
                alu_c   = wide[W];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        z_d       = z_q;
        n_d       = n_q;
        v_d       = v_q;
        c_d       = c_q;
        mul_start = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d   = StBusy;
                        mul_start = 1'b1;
                    end else begin
                        state_d = StDone;
                        res_d   = alu_res;
                        z_d     = (alu_res == '0);
                        n_d     = alu_res[W-1];
                        v_d     = alu_v;
                        c_d     = alu_c;
                    end
                end else if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                if (mul_busy && mul_done) begin
                    state_d = StDone;
                    res_d   = mul_prod[W-1:0];
                    z_d     = (mul_prod[W-1:0] == '0);
                    n_d     = mul_prod[W-1];
                    v_d     = (mul_prod[2*W-1:W] != '0);
                    c_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            res_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            c_q     <= c_d;
        end
    end

    if (MUL_EN) begin : g_mul
        alu_mc_mul #(
            .W (W)
        ) u_mul (
            .clk       (clk),
            .rst_n     (rst_n),
            .start_i   (mul_start),
            .a_i       (val_A),
            .b_i       (val_B),
            .busy_o    (mul_busy),
            .done_o    (mul_done),
            .product_o (mul_prod)
        );
    end else begin : g_no_mul
        assign mul_busy = 1'b0;
        assign mul_done = 1'b0;
        assign mul_prod = '0;
    end

    assign ALU_out = res_q;
    assign Z       = z_q;
    assign N       = n_q;
    assign V       = v_q;
    assign C       = c_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc (W=16) against an arithmetic reference model.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [15:0] val_A = 16'd0;
    logic [15:0] val_B = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] ALU_out;
    logic        Z, N, V, C;

    int errors = 0;
    int checks = 0;

    alu_mc #(
        .W      (16),
        .MUL_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .val_A     (val_A),
        .val_B     (val_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_out   (ALU_out),
        .Z         (Z),
        .N         (N),
        .V         (V),
        .C         (C)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns {result[15:0], Z, N, V, C}.
    function automatic logic [19:0] model(input logic [2:0] o, input logic [15:0] a,
                                          input logic [15:0] b);
        int          sa, sb, s;
        logic [31:0] t;
        logic [15:0] r;
        logic        v, c;
        sa = $signed(a);
        sb = $signed(b);
        s  = 0;
        t  = 32'd0;
        r  = 16'd0;
        v  = 1'b0;
        c  = 1'b0;
        case (o)
            3'd0: begin
                t = 32'(a) + 32'(b);
                r = t[15:0];
                c = t[16];
                s = sa + sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd2: r = a & b;
            3'd3: r = ~b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin
                t = 32'(a) << b[3:0];
                r = t[15:0];
                c = t[16];
            end
            default: begin
                t = 32'(a) * 32'(b);
                r = t[15:0];
                v = (t[31:16] != 16'd0);
            end
        endcase
        return {r, (r == 16'd0), r[15], v, c};
    endfunction

    // Issue one op, check latency and result, then consume it.
    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [19:0] e;
        int          n;
        int          lat;
        int          hold;
        e = model(o, a, b);
        in_valid  = 1'b1;
        op        = o;
        val_A     = a;
        val_B     = b;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 64) begin
            step();
            n++;
        end
        chk("in_ready", 32'(in_ready), 32'd1);
        step();
        // Scramble inputs: the DUT must have captured them already.
        in_valid = 1'b0;
        op       = 3'($urandom);
        val_A    = 16'($urandom);
        val_B    = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), (o == 3'd7) ? 32'd17 : 32'd1);
        hold = $urandom_range(0, 2);
        repeat (hold) step();
        chk("result", 32'(ALU_out), 32'(e[19:4]));
        chk("flags", {28'd0, Z, N, V, C}, {28'd0, e[3:0]});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("consumed", 32'(out_valid), 32'd0);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] hold_res;
        logic [3:0]  hold_flags;
        int          n;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_alu_out", 32'(ALU_out), 32'd0);
        chk("rst_flags", {28'd0, Z, N, V, C}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed cases from the boundary list.
        run_op(3'd0, 16'h7FFF, 16'h0001);
        run_op(3'd1, 16'h8000, 16'h0001);
        run_op(3'd1, 16'h0003, 16'h0003);
        run_op(3'd7, 16'h0100, 16'h0100);
        run_op(3'd7, 16'd300, 16'd7);
        run_op(3'd6, 16'hC001, 16'h0001);
        run_op(3'd6, 16'h1234, 16'h0010);
        run_op(3'd3, 16'h5555, 16'h0F0F);

        // Backpressure: hold a result while a new op waits, then consume and accept together.
        in_valid = 1'b1;
        op       = 3'd5;
        val_A    = 16'hA5A5;
        val_B    = 16'h0FF0;
        step();
        op    = 3'd0;
        val_A = 16'd1;
        val_B = 16'd1;
        hold_res   = ALU_out;
        hold_flags = {Z, N, V, C};
        chk("bp_first", 32'(hold_res), 32'h0000AA55);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("bp_stable", {12'd0, ALU_out, Z, N, V, C}, {12'd0, hold_res, hold_flags});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_follow", 32'(in_ready), 32'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_result", 32'(ALU_out), 32'd2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset in the middle of a multiply.
        in_valid = 1'b1;
        op       = 3'd7;
        val_A    = 16'h1234;
        val_B    = 16'h0055;
        n = 0;
        while (!in_ready && n < 64) begin
            step();
            n++;
        end
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("mul_busy_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out", {12'd0, ALU_out, Z, N, V, C}, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        run_op(3'd7, 16'd1234, 16'd3);

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU. It extends the datapath's 2-bit combinational ALU with a width parameter, three more ops, an iterative multiplier and a carry flag. Results and flags are held in registers, and the block talks to the sequencer through valid/ready handshakes on both sides. It sits between the register-file read stage and the write-back/status-register stage of the datapath.

Parameters:
- W, 16, operand and result width in bits; must be at least 4.
- MUL_EN, 1, when 1, op MUL is implemented; when 0, MUL is treated as an illegal op.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous, active-low reset.
- in_valid, input, 1, op and operands are presented.
- in_ready, output, 1, block can accept an op this cycle.
- op, input, 3, operation select, encoded in alu_mc_pkg.
- val_A, input, W, operand A.
- val_B, input, W, operand B (also supplies the shift amount).
- out_valid, output, 1, ALU_out and flags are valid.
- out_ready, input, 1, consumer takes the result this cycle.
- ALU_out, output, W, registered result.
- Z, output, 1, result is zero.
- N, output, 1, result MSB.
- V, output, 1, signed overflow (ADD/SUB) or unsigned product overflow (MUL).
- C, output, 1, carry, no-borrow, or last bit shifted out.

Behaviour:
- One clock: clk. Reset rst_n is asynchronous and active-low. While rst_n=0:
  - state=IDLE;
  - in_ready=0, out_valid=0;
  - ALU_out=0, Z=0, N=0, V=0, C=0;
  - multiply counter=0.
- Transfers: an op is accepted on a clk edge where in_valid & in_ready. A result is consumed on an edge where out_valid & out_ready. val_A, val_B and op are captured at acceptance; later input changes are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Accepting a single-cycle op goes to DONE, with result and flags registered on that same edge (latency 1). Accepting MUL goes to BUSY.
  - BUSY: in_ready=0. Each cycle performs one shift-add step using the captured operands and a counter from 0 to W-1. At count W-1 the result and flags are registered and the state goes to DONE. MUL latency is W+1 cycles from acceptance to out_valid.
  - DONE: out_valid=1 and outputs are held stable until consumed. in_ready = out_ready.
    - Consume with no new op: go to IDLE.
    - Consume and accept on the same edge: back-to-back operation. Next state is DONE (single-cycle op) or BUSY (MUL).
    - When in_valid=1 but out_ready=0, the op waits (in_ready=0).
- Ops (all arithmetic is modulo 2^W):
  - ADD: A+B. C=carry out. V=1 when A and B have the same sign and the result sign differs.
  - SUB: A-B. C=1 when A>=B unsigned. V=1 when A and B have different signs and the result sign differs from A, covering both sign cases.
  - AND: A&B. V=0, C=0.
  - OR: A|B. V=0, C=0.
  - XOR: A^B. V=0, C=0.
  - NOTB: ~B. V=0, C=0.
  - SHL: A << B[$clog2(W)-1:0]. C = last bit shifted out; C=0 for a shift of 0. V=0.
  - MUL: unsigned A*B, low W bits. V=1 when the high W bits are nonzero. C=0.
- Flags for every op: Z = (result==0), N = result[W-1].
- Illegal op (MUL with MUL_EN=0, or an unused encoding): the op is accepted and completes in 1 cycle with ALU_out=0, Z=1, N=0, V=0, C=0.
- Reset asserted mid-MUL or while in DONE: the op is abandoned and the result is lost. There is no output glitch beyond the asynchronous clear to reset values.

Decomposition:
- alu_mc_pkg holds:
  - the op_e typedef: ADD=0, SUB=1, AND=2, NOTB=3, OR=4, XOR=5, SHL=6, MUL=7. Codes 0-3 match the existing 2-bit ALU encoding.
  - the state_e typedef (IDLE/BUSY/DONE).
- One sub-module, alu_mc_mul: a W-cycle shift-add multiplier with start/busy/done signals and a 2W-bit product. It exists only when MUL_EN=1.

Test Plan:
- W=16, after reset: ADD A=16'h7FFF, B=16'h0001 -> one cycle later out_valid=1, ALU_out=16'h8000, N=1, V=1, C=0, Z=0.
- SUB A=16'h8000, B=16'h0001 -> ALU_out=16'h7FFF, V=1, C=1. SUB A=16'h0003, B=16'h0003 -> ALU_out=0, Z=1, C=1.
- MUL A=16'h0100, B=16'h0100 -> out_valid exactly 17 cycles after acceptance, ALU_out=0, Z=1, V=1. MUL 16'd300 * 16'd7 -> ALU_out=16'd2100, V=0.
- SHL A=16'hC001, B=16'h0001 -> ALU_out=16'h8002, C=1. SHL with B=16'h0010 (shift amount 0) -> ALU_out=A, C=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> ALU_out and flags stable, in_ready=0. Then raise out_ready with in_valid=1 carrying ADD 1+1 -> consume and accept on the same edge, and the next cycle shows ALU_out=2.
- Drop rst_n at MUL cycle 8 -> immediately out_valid=0, ALU_out=0. After release, in_ready=1 and the next op behaves normally.
